// File: rtl/jk_excitation_ctrl.sv
// ---------------------------------------------------------------------------
// jk_excitation_ctrl
//
// Drives the J/K inputs of an external WIDTH-bit bank of positive-edge JK
// flip-flops so that the bank moves from its current state (Q feedback) to a
// requested target. Targets arrive over a valid/ready handshake. After the
// drive edge, Q is checked against the target. On a mismatch the bank is
// re-driven, up to MAX_RETRY extra times, and then the sticky error state is
// entered.
//
// Optional build macro:
//   JK_TOGGLE_EN - use toggle encoding (J = K = T ^ Q) instead of the default
//                  set/reset encoding (J = T & ~Q, K = ~T & Q).
//
// Parameters:
//   WIDTH      - number of JK flip-flops in the driven bank
//   MAX_RETRY  - extra drive attempts after a failed check (1..15)
//
// Ports:
//   clk_i        - clock, rising edge (shared with the JK bank)
//   rst_i        - asynchronous active-high reset
//   tgt_valid_i  - target request valid
//   tgt_ready_o  - controller can accept a target (IDLE / ERR)
//   tgt_data_i   - requested bank state
//   q_i          - feedback from the JK bank outputs
//   j_o, k_o     - excitation to the bank (non-zero only in DRIVE)
//   busy_o       - high in DRIVE and CHECK
//   done_o       - one-cycle pulse after a successful check
//   err_o        - sticky failure flag (high while in ERR)
// ---------------------------------------------------------------------------
module jk_excitation_ctrl #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tgt_valid_i,
  output logic             tgt_ready_o,
  input  logic [WIDTH-1:0] tgt_data_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [3:0]       retry_q, retry_d;
  logic             done_q, done_d;

  // J excitation for moving each bit from q to t.
  function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] t,
                                                input logic [WIDTH-1:0] q);
`ifdef JK_TOGGLE_EN
    excite_j = t ^ q;
`else
    excite_j = t & ~q;
`endif
  endfunction

  // K excitation for moving each bit from q to t.
  function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] t,
                                                input logic [WIDTH-1:0] q);
`ifdef JK_TOGGLE_EN
    excite_k = t ^ q;
`else
    excite_k = ~t & q;
`endif
  endfunction

  // Next-state logic for the control FSM, target, retry count and done pulse.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    retry_d  = retry_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR: begin
        // Ready is high in both states, so valid alone completes a handshake.
        if (tgt_valid_i) begin
          target_d = tgt_data_i;
          retry_d  = 4'd0;
          state_d  = ST_DRIVE;
        end else begin
          state_d  = state_q;
        end
      end
      ST_DRIVE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (q_i == target_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (retry_q < MAX_RETRY_C) begin
          retry_d = retry_q + 4'd1;
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      retry_q  <= 4'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      retry_q  <= retry_d;
      done_q   <= done_d;
    end
  end

  // Output decode from registered state, target and bank feedback only.
  always_comb begin
    tgt_ready_o = (state_q == ST_IDLE) || (state_q == ST_ERR);
    busy_o      = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
    err_o       = (state_q == ST_ERR);
    done_o      = done_q;
    if (state_q == ST_DRIVE) begin
      // Recomputed from live Q so a retry only drives bits still wrong.
      j_o = excite_j(target_q, q_i);
      k_o = excite_k(target_q, q_i);
    end else begin
      j_o = '0;
      k_o = '0;
    end
  end

endmodule

// File: doc/jk_excitation_ctrl.md
Name: jk_excitation_ctrl

Overview:
- Controller that drives the J/K inputs of an external WIDTH-bit bank of positive-edge JK flip-flops, moving the bank from its current state to a requested target.
- Accepts targets over a valid/ready handshake and computes the JK excitation from the target and the bank's Q feedback.
- After the drive edge it checks Q against the target, retries on mismatch, and reports Done or Err.
- Sits between sequencing/control logic and the JK register bank. Its function is the inverse of the JK next-state equation.

Parameters:
- WIDTH, 4, number of JK flip-flops in the driven bank.
- MAX_RETRY, 3, number of extra drive attempts after a failed check before Err is declared (1..15).

Ports:
- Clock  input  1  single clock, rising edge; the driven JK bank shares this clock.
- Reset  input  1  asynchronous, active-high reset.
- TgtValid  input  1  target request valid.
- TgtReady  output  1  controller can accept a target.
- TgtData  input  WIDTH  requested bank state.
- Q  input  WIDTH  feedback from the JK bank outputs.
- J  output  WIDTH  J inputs to the bank.
- K  output  WIDTH  K inputs to the bank.
- Busy  output  1  high in DRIVE and CHECK.
- Done  output  1  one-cycle pulse on a successful check.
- Err  output  1  sticky failure flag.

Behaviour:
- Interface: one clock (Clock); reset is asynchronous and active-high (Reset).
- States: IDLE, DRIVE, CHECK, ERR. A 4-bit retry counter and a WIDTH-bit target register.
- Reset (async, takes effect immediately):
  - state=IDLE, target=0, retry=0.
  - J=0, K=0, Done=0, Err=0, Busy=0.
  - TgtReady decodes high in IDLE, but no handshake is accepted while Reset=1.
- Outputs are a pure decode of registered state, target and Q. There are no combinational paths from TgtValid or TgtData.
- IDLE:
  - TgtReady=1, J=K=0 (bank holds).
  - On TgtValid & TgtReady at a rising edge: capture TgtData, clear retry, go to DRIVE. Done and Err clear on that edge.
- DRIVE (exactly one cycle):
  - Per bit, default set/reset encoding: J = T & ~Q, K = ~T & Q. Bits already at target get J=K=0.
  - The bank updates on the edge that ends DRIVE. Next state is CHECK.
- CHECK (one cycle): J=K=0, compare Q with the target.
  - Q==target: Done=1 for the following cycle, then IDLE.
  - Mismatch with retry<MAX_RETRY: retry+1, back to DRIVE. Excitation is recomputed from the current Q.
  - Mismatch with retry==MAX_RETRY: go to ERR.
- ERR:
  - Err=1, Busy=0, TgtReady=1, J=K=0.
  - A new accepted target clears Err and goes to DRIVE. This is the only exit besides Reset.
- TgtReady=0 in DRIVE and CHECK; TgtValid is ignored there. The upstream must hold TgtValid/TgtData until accepted.
- A target equal to the current Q still passes DRIVE (with J=K=0) and CHECK. Latency is identical.
- Latency from accept edge to Done pulse: 3 cycles with no retries, plus 2 cycles per retry.
- Reset mid-DRIVE forces J=K=0 immediately. The bank's state is undefined only if Reset deasserts within setup of the same edge; this is not required to be handled.

Optional Feature:
- Macro: JK_TOGGLE_EN.
- When defined, DRIVE uses toggle encoding: J = K = T ^ Q per bit. Every bit needing a change toggles; unchanged bits get J=K=0.
- When undefined, the set/reset encoding above applies.
- Handshake, states, latency and checking are identical in both builds. With the macro defined, J==K holds on every bit in every cycle.

Test Plan:
- Reset: assert Reset mid-DRIVE with WIDTH=4 -> J=K=0000, Busy=0, Done=0, Err=0 immediately; TgtReady=1 after release.
- Basic set/reset: bank Q=0000, target 1010 -> DRIVE J=1010, K=0000; CHECK Q=1010; Done pulses on the 3rd cycle after accept. Then target 0110 -> J=0100, K=1000.
- No-change target: Q=0101, target 0101 -> J=K=0000 in DRIVE; Done after 3 cycles; TgtReady=0 for cycles 1-2.
- Retry then success: force bank bit0 stuck at 0 for the first drive only, target 0001 -> one retry (J=0001 again), Done after 5 cycles, Err=0.
- Retry exhaustion: bit3 stuck at 0, target 1000, MAX_RETRY=3 -> 4 DRIVE cycles, then ERR with Err=1 sticky. A new target 0000 clears Err and ends with Done.
- JK_TOGGLE_EN build: Q=1100, target 1010 -> J=K=0110 in DRIVE; Done after 3 cycles; bench asserts J==K on all cycles.
